// File: rtl/alu_issue_queue.sv
// ALU issue queue: buffers dispatched instructions, wakes pending operands from
// the completion bus and issues the oldest ready entry into a registered output slot.

module alu_iq_operand #(
  parameter int TAG_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             alloc_i,
  input  logic             wake_en_i,
  input  logic             src_valid_i,
  input  logic [31:0]      src_data_i,
  input  logic [TAG_W-1:0] src_tag_i,
  input  logic             cdb_valid_i,
  input  logic [TAG_W-1:0] cdb_tag_i,
  input  logic [31:0]      cdb_data_i,
  output logic             rdy_o,
  output logic [31:0]      data_o
);
  logic             rdy_q, rdy_d;
  logic [31:0]      data_q, data_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             cap_hit, wake_hit;

  // A producer completing in the dispatch cycle is captured directly.
  assign cap_hit  = !src_valid_i && cdb_valid_i && (cdb_tag_i == src_tag_i);
  assign wake_hit = wake_en_i && !rdy_q && cdb_valid_i && (cdb_tag_i == tag_q);

  always_comb begin
    rdy_d  = rdy_q;
    data_d = data_q;
    tag_d  = tag_q;
    if (alloc_i) begin
      rdy_d  = src_valid_i | cap_hit;
      data_d = cap_hit ? cdb_data_i : src_data_i;
      tag_d  = src_tag_i;
    end else if (wake_hit) begin
      rdy_d  = 1'b1;
      data_d = cdb_data_i;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdy_q  <= 1'b0;
      data_q <= '0;
      tag_q  <= '0;
    end else begin
      rdy_q  <= rdy_d;
      data_q <= data_d;
      tag_q  <= tag_d;
    end
  end

  assign rdy_o  = rdy_q;
  assign data_o = data_q;
endmodule

module alu_iq_entry #(
  parameter int TAG_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flash,
  input  logic             alloc_i,
  input  logic             free_i,
  input  logic [31:0]      instr_i,
  input  logic [31:0]      pc_i,
  input  logic             approx_i,
  input  logic [TAG_W-1:0] dest_tag_i,
  input  logic             src1_valid_i,
  input  logic [31:0]      src1_data_i,
  input  logic [TAG_W-1:0] src1_tag_i,
  input  logic             src2_valid_i,
  input  logic [31:0]      src2_data_i,
  input  logic [TAG_W-1:0] src2_tag_i,
  input  logic             cdb_valid_i,
  input  logic [TAG_W-1:0] cdb_tag_i,
  input  logic [31:0]      cdb_data_i,
  output logic             valid_o,
  output logic             ready_o,
  output logic [31:0]      instr_o,
  output logic [31:0]      pc_o,
  output logic             approx_o,
  output logic [TAG_W-1:0] dest_tag_o,
  output logic [31:0]      src1_o,
  output logic [31:0]      src2_o
);
  logic             valid_q, valid_d;
  logic [31:0]      instr_q, pc_q;
  logic             approx_q;
  logic [TAG_W-1:0] dest_q;
  logic             rdy1, rdy2, wake_en;

  // CDB traffic in a flush cycle belongs to squashed work.
  assign wake_en = valid_q && !flash;

  always_comb begin
    valid_d = valid_q;
    if (flash)        valid_d = 1'b0;
    else if (alloc_i) valid_d = 1'b1;
    else if (free_i)  valid_d = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q  <= 1'b0;
      instr_q  <= '0;
      pc_q     <= '0;
      approx_q <= 1'b0;
      dest_q   <= '0;
    end else begin
      valid_q <= valid_d;
      if (alloc_i) begin
        instr_q  <= instr_i;
        pc_q     <= pc_i;
        approx_q <= approx_i;
        dest_q   <= dest_tag_i;
      end
    end
  end

  alu_iq_operand #(.TAG_W(TAG_W)) u_op1 (
    .clock(clock), .reset(reset), .alloc_i(alloc_i), .wake_en_i(wake_en),
    .src_valid_i(src1_valid_i), .src_data_i(src1_data_i), .src_tag_i(src1_tag_i),
    .cdb_valid_i(cdb_valid_i), .cdb_tag_i(cdb_tag_i), .cdb_data_i(cdb_data_i),
    .rdy_o(rdy1), .data_o(src1_o)
  );

  alu_iq_operand #(.TAG_W(TAG_W)) u_op2 (
    .clock(clock), .reset(reset), .alloc_i(alloc_i), .wake_en_i(wake_en),
    .src_valid_i(src2_valid_i), .src_data_i(src2_data_i), .src_tag_i(src2_tag_i),
    .cdb_valid_i(cdb_valid_i), .cdb_tag_i(cdb_tag_i), .cdb_data_i(cdb_data_i),
    .rdy_o(rdy2), .data_o(src2_o)
  );

  assign valid_o    = valid_q;
  assign ready_o    = valid_q & rdy1 & rdy2;
  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign approx_o   = approx_q;
  assign dest_tag_o = dest_q;
endmodule

module alu_issue_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flash,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc,
  input  logic             in_approx,
  input  logic             in_src1_valid,
  input  logic [31:0]      in_src1_data,
  input  logic [TAG_W-1:0] in_src1_tag,
  input  logic             in_src2_valid,
  input  logic [31:0]      in_src2_data,
  input  logic [TAG_W-1:0] in_src2_tag,
  input  logic [TAG_W-1:0] in_dest_tag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_pc,
  output logic             out_approx,
  output logic [31:0]      out_src1,
  output logic [31:0]      out_src2,
  output logic [TAG_W-1:0] out_dest_tag
);
  logic [DEPTH-1:0]             e_valid, e_ready, e_approx;
  logic [DEPTH-1:0][31:0]       e_instr, e_pc, e_src1, e_src2;
  logic [DEPTH-1:0][TAG_W-1:0]  e_dest;
  logic [DEPTH-1:0]             alloc_oh, sel, free;
  logic                         accept, has_cand, load, found;
  // older_q[j][i] set means entry j was dispatched before entry i.
  logic [DEPTH-1:0][DEPTH-1:0]  older_q, older_d;

  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_instr_q, out_instr_d, out_pc_q, out_pc_d;
  logic             out_approx_q, out_approx_d;
  logic [31:0]      out_src1_q, out_src1_d, out_src2_q, out_src2_d;
  logic [TAG_W-1:0] out_dest_q, out_dest_d;

  assign in_ready = ~&e_valid;
  assign accept   = in_valid && in_ready && !flash;
  assign has_cand = |e_ready;
  assign load     = (!out_valid_q || out_ready) && has_cand && !flash;
  assign free     = load ? sel : '0;

  always_comb begin
    alloc_oh = '0;
    found    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!e_valid[i] && !found) begin
        alloc_oh[i] = accept;
        found       = 1'b1;
      end
    end
  end

  always_comb begin
    sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sel[i] = e_ready[i];
      for (int j = 0; j < DEPTH; j++)
        if (j != i && e_ready[j] && older_q[j][i]) sel[i] = 1'b0;
    end
  end

  always_comb begin
    older_d = older_q;
    if (flash) begin
      older_d = '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (alloc_oh[k]) begin
          for (int j = 0; j < DEPTH; j++) begin
            older_d[k][j] = 1'b0;
            older_d[j][k] = (j != k);
          end
        end
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_ent
      alu_iq_entry #(.TAG_W(TAG_W)) u_ent (
        .clock(clock), .reset(reset), .flash(flash),
        .alloc_i(alloc_oh[g]), .free_i(free[g]),
        .instr_i(in_instr), .pc_i(in_pc), .approx_i(in_approx), .dest_tag_i(in_dest_tag),
        .src1_valid_i(in_src1_valid), .src1_data_i(in_src1_data), .src1_tag_i(in_src1_tag),
        .src2_valid_i(in_src2_valid), .src2_data_i(in_src2_data), .src2_tag_i(in_src2_tag),
        .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag), .cdb_data_i(cdb_data),
        .valid_o(e_valid[g]), .ready_o(e_ready[g]),
        .instr_o(e_instr[g]), .pc_o(e_pc[g]), .approx_o(e_approx[g]),
        .dest_tag_o(e_dest[g]), .src1_o(e_src1[g]), .src2_o(e_src2[g])
      );
    end
  endgenerate

  always_comb begin
    out_valid_d  = out_valid_q;
    out_instr_d  = out_instr_q;
    out_pc_d     = out_pc_q;
    out_approx_d = out_approx_q;
    out_src1_d   = out_src1_q;
    out_src2_d   = out_src2_q;
    out_dest_d   = out_dest_q;
    if (flash) begin
      out_valid_d = 1'b0;
    end else if (load) begin
      out_valid_d  = 1'b1;
      out_instr_d  = '0;
      out_pc_d     = '0;
      out_approx_d = 1'b0;
      out_src1_d   = '0;
      out_src2_d   = '0;
      out_dest_d   = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (sel[i]) begin
          out_instr_d  = out_instr_d  | e_instr[i];
          out_pc_d     = out_pc_d     | e_pc[i];
          out_approx_d = out_approx_d | e_approx[i];
          out_src1_d   = out_src1_d   | e_src1[i];
          out_src2_d   = out_src2_d   | e_src2[i];
          out_dest_d   = out_dest_d   | e_dest[i];
        end
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      older_q      <= '0;
      out_valid_q  <= 1'b0;
      out_instr_q  <= '0;
      out_pc_q     <= '0;
      out_approx_q <= 1'b0;
      out_src1_q   <= '0;
      out_src2_q   <= '0;
      out_dest_q   <= '0;
    end else begin
      older_q      <= older_d;
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_pc_q     <= out_pc_d;
      out_approx_q <= out_approx_d;
      out_src1_q   <= out_src1_d;
      out_src2_q   <= out_src2_d;
      out_dest_q   <= out_dest_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_instr    = out_instr_q;
  assign out_pc       = out_pc_q;
  assign out_approx   = out_approx_q;
  assign out_src1     = out_src1_q;
  assign out_src2     = out_src2_q;
  assign out_dest_tag = out_dest_q;
endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue; issued instructions are checked against a
// scoreboard filled in expected issue order as stimulus is driven.

module tb_alu_issue_queue;
  localparam int DEPTH = 4;
  localparam int TAG_W = 6;

  logic             clock = 1'b0;
  logic             reset, flash, in_valid, in_ready, in_approx;
  logic [31:0]      in_instr, in_pc, in_src1_data, in_src2_data;
  logic             in_src1_valid, in_src2_valid;
  logic [TAG_W-1:0] in_src1_tag, in_src2_tag, in_dest_tag;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_data;
  logic             out_valid, out_ready, out_approx;
  logic [31:0]      out_instr, out_pc, out_src1, out_src2;
  logic [TAG_W-1:0] out_dest_tag;

  typedef struct packed {
    logic [31:0]      instr, pc, src1, src2;
    logic             approx;
    logic [TAG_W-1:0] dest;
  } exp_t;

  exp_t sbq[$];
  int errors = 0;
  int checks = 0;

  alu_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clock(clock), .reset(reset), .flash(flash),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .in_approx(in_approx),
    .in_src1_valid(in_src1_valid), .in_src1_data(in_src1_data), .in_src1_tag(in_src1_tag),
    .in_src2_valid(in_src2_valid), .in_src2_data(in_src2_data), .in_src2_tag(in_src2_tag),
    .in_dest_tag(in_dest_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_approx(out_approx), .out_src1(out_src1), .out_src2(out_src2),
    .out_dest_tag(out_dest_tag)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] s1,
                      input logic [31:0] s2, input logic [TAG_W-1:0] dst);
    exp_t e;
    e.instr = ins; e.pc = pc; e.src1 = s1; e.src2 = s2; e.approx = ins[0]; e.dest = dst;
    sbq.push_back(e);
  endtask

  task automatic dispatch(input logic [31:0] ins, input logic [31:0] pc,
                          input logic s1v, input logic [31:0] s1, input logic [TAG_W-1:0] t1,
                          input logic s2v, input logic [31:0] s2, input logic [TAG_W-1:0] t2,
                          input logic [TAG_W-1:0] dst);
    in_instr = ins; in_pc = pc; in_approx = ins[0]; in_dest_tag = dst;
    in_src1_valid = s1v; in_src1_data = s1; in_src1_tag = t1;
    in_src2_valid = s2v; in_src2_data = s2; in_src2_tag = t2;
    in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
  endtask

  task automatic cdb(input logic [TAG_W-1:0] t, input logic [31:0] d);
    cdb_valid = 1'b1; cdb_tag = t; cdb_data = d;
    step(1);
    cdb_valid = 1'b0;
  endtask

  // Every handshake on the issue port must match the head of the scoreboard.
  always @(negedge clock) begin : mon
    exp_t e;
    if (reset && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_issue: observed instr=%0h expected no issue", out_instr);
      end else begin
        e = sbq.pop_front();
        chk("issue_instr", out_instr, e.instr);
        chk("issue_pc", out_pc, e.pc);
        chk("issue_src1", out_src1, e.src1);
        chk("issue_src2", out_src2, e.src2);
        chk("issue_approx", 32'(out_approx), 32'(e.approx));
        chk("issue_dest", 32'(out_dest_tag), 32'(e.dest));
      end
    end
  end

  initial begin
    reset = 1'b0; flash = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_pc = '0; in_approx = 1'b0; in_dest_tag = '0;
    in_src1_valid = 1'b0; in_src1_data = '0; in_src1_tag = '0;
    in_src2_valid = 1'b0; in_src2_data = '0; in_src2_tag = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_src1", out_src1, 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    step(1);

    // Ready operands: one-cycle dispatch-to-issue.
    push(32'h13, 32'h100, 32'd5, 32'd7, 6'd3);
    dispatch(32'h13, 32'h100, 1'b1, 32'd5, 6'd0, 1'b1, 32'd7, 6'd0, 6'd3);
    @(negedge clock);
    chk("t1_not_early", 32'(out_valid), 32'd0);
    @(posedge clock); #1;
    chk("t1_out_valid", 32'(out_valid), 32'd1);
    chk("t1_out_src2", out_src2, 32'd7);
    step(2);

    // Wakeup: a non-matching tag must not wake, the matching one two cycles later does.
    dispatch(32'h2, 32'h104, 1'b0, 32'd0, 6'd9, 1'b1, 32'h22, 6'd0, 6'd10);
    cdb(6'd8, 32'h1111);
    push(32'h2, 32'h104, 32'hDEADBEEF, 32'h22, 6'd10);
    cdb(6'd9, 32'hDEADBEEF);
    chk("t2_no_early_issue", 32'(out_valid), 32'd0);
    step(1);
    chk("t2_issued", 32'(out_valid), 32'd1);
    chk("t2_src1", out_src1, 32'hDEADBEEF);
    step(2);

    // Both operands waiting on the same tag wake together.
    dispatch(32'h5, 32'h10C, 1'b0, 32'd0, 6'd12, 1'b0, 32'd0, 6'd12, 6'd13);
    push(32'h5, 32'h10C, 32'hABC, 32'hABC, 6'd13);
    cdb(6'd12, 32'hABC);
    step(3);

    // Capture bypass: operand completes on the CDB in the dispatch cycle.
    cdb_valid = 1'b1; cdb_tag = 6'd4; cdb_data = 32'h55;
    push(32'h3, 32'h108, 32'h66, 32'h55, 6'd5);
    dispatch(32'h3, 32'h108, 1'b1, 32'h66, 6'd0, 1'b0, 32'd0, 6'd4, 6'd5);
    cdb_valid = 1'b0;
    step(1);
    chk("t3_issued", 32'(out_valid), 32'd1);
    chk("t3_src2", out_src2, 32'h55);
    step(2);

    // Age order under backpressure; fifth dispatch fills the queue.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push(32'hA0 + 32'(i * 16), 32'h200 + 32'(i * 4), 32'(i + 1), 32'(i + 100), 6'(i + 1));
      dispatch(32'hA0 + 32'(i * 16), 32'h200 + 32'(i * 4), 1'b1, 32'(i + 1), 6'd0,
               1'b1, 32'(i + 100), 6'd0, 6'(i + 1));
    end
    chk("t4_hold_instr", out_instr, 32'hA0);
    step(2);
    chk("t4_hold_instr2", out_instr, 32'hA0);
    chk("t4_hold_src1", out_src1, 32'd1);
    chk("t4_hold_valid", 32'(out_valid), 32'd1);
    for (int i = 3; i < 5; i++) begin
      push(32'hA0 + 32'(i * 16), 32'h200 + 32'(i * 4), 32'(i + 1), 32'(i + 100), 6'(i + 1));
      dispatch(32'hA0 + 32'(i * 16), 32'h200 + 32'(i * 4), 1'b1, 32'(i + 1), 6'd0,
               1'b1, 32'(i + 100), 6'd0, 6'(i + 1));
    end
    chk("t4_full", 32'(in_ready), 32'd0);
    dispatch(32'hF0, 32'h300, 1'b1, 32'd9, 6'd0, 1'b1, 32'd9, 6'd0, 6'd9);
    chk("t4_full_ignored", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    step(7);
    chk("t4_drained", 32'(sbq.size()), 32'd0);
    chk("t4_idle", 32'(out_valid), 32'd0);

    // Four pending entries; waking the youngest issues it alone.
    for (int i = 0; i < 4; i++)
      dispatch(32'h50 + 32'(i), 32'h400 + 32'(i * 4), 1'b0, 32'd0, 6'(20 + i),
               1'b1, 32'h77, 6'd0, 6'(30 + i));
    chk("t5_full", 32'(in_ready), 32'd0);
    chk("t5_no_issue", 32'(out_valid), 32'd0);
    push(32'h53, 32'h40C, 32'h2323, 32'h77, 6'd33);
    cdb(6'd23, 32'h2323);
    step(2);
    chk("t5_one_free", 32'(in_ready), 32'd1);
    chk("t5_others_wait", 32'(out_valid), 32'd0);

    // Flush with three queued and a held output; dispatch and CDB in that cycle are dropped.
    out_ready = 1'b0;
    dispatch(32'h60, 32'h500, 1'b1, 32'd1, 6'd0, 1'b1, 32'd2, 6'd0, 6'd7);
    step(1);
    chk("t6_pre_valid", 32'(out_valid), 32'd1);
    chk("t6_pre_full", 32'(in_ready), 32'd1);
    flash = 1'b1; cdb_valid = 1'b1; cdb_tag = 6'd20; cdb_data = 32'h9;
    dispatch(32'h61, 32'h504, 1'b1, 32'd3, 6'd0, 1'b1, 32'd4, 6'd0, 6'd8);
    flash = 1'b0; cdb_valid = 1'b0;
    chk("t6_out_valid", 32'(out_valid), 32'd0);
    chk("t6_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) cdb(6'(20 + i), 32'h44);
    step(2);
    chk("t6_no_issue", 32'(out_valid), 32'd0);

    // After flush, two entries woken together issue oldest first.
    dispatch(32'h70, 32'h600, 1'b0, 32'd0, 6'd30, 1'b1, 32'd1, 6'd0, 6'd1);
    dispatch(32'h71, 32'h604, 1'b0, 32'd0, 6'd30, 1'b1, 32'd2, 6'd0, 6'd2);
    push(32'h70, 32'h600, 32'h3030, 32'd1, 6'd1);
    push(32'h71, 32'h604, 32'h3030, 32'd2, 6'd2);
    cdb(6'd30, 32'h3030);
    step(4);
    chk("t7_drained", 32'(sbq.size()), 32'd0);

    // Asynchronous reset while the output is stalled clears immediately.
    out_ready = 1'b0;
    dispatch(32'h80, 32'h700, 1'b1, 32'd5, 6'd0, 1'b1, 32'd6, 6'd0, 6'd4);
    dispatch(32'h81, 32'h704, 1'b1, 32'd7, 6'd0, 1'b1, 32'd8, 6'd0, 6'd5);
    chk("t8_pre_valid", 32'(out_valid), 32'd1);
    #3 reset = 1'b0;
    #1;
    chk("t8_out_valid", 32'(out_valid), 32'd0);
    chk("t8_in_ready", 32'(in_ready), 32'd1);
    chk("t8_out_instr", out_instr, 32'd0);
    chk("t8_out_src1", out_src1, 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    out_ready = 1'b1;
    step(4);
    chk("t8_no_issue", 32'(out_valid), 32'd0);
    chk("final_sb_empty", 32'(sbq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
